// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the McCoy control sequencer: opcode values,
// FSM state encoding and x8 write-source encodings.
package mccoy_pkg;

    // Opcode values, decoded from opcode[2:0]
    localparam logic [2:0] OP_LI   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_BEZ  = 3'b010;
    localparam logic [2:0] OP_LR   = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;
    localparam logic [2:0] OP_SR   = 3'b101;
    localparam logic [2:0] OP_JA   = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    // x8 write-source selects
    localparam logic [1:0] X8_MEM = 2'd0;
    localparam logic [1:0] X8_IMM = 2'd1;
    localparam logic [1:0] X8_ALU = 2'd2;
    localparam logic [1:0] X8_NOT = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational opcode decode for the McCoy sequencer.
// Build option: CTRL_HALT_EN makes opcode 100 a halt instead of illegal.
module ctrl_decode
    import mccoy_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int X8SEL_W = 2
) (
    input  logic [OPW-1:0]     opcode,
    output logic               op1,
    output logic               op2,
    output logic [X8SEL_W-1:0] x8_sel,
    output logic               is_mem,
    output logic               is_st,
    output logic               is_br,
    output logic               is_jmp,
    output logic               writes_x8,
    output logic               is_halt,
    output logic               illegal
);

    logic hi_bad;

    // Any set bit above the 3-bit opcode field makes the instruction illegal
    generate
        if (OPW > 3) begin : g_hi
            assign hi_bad = |opcode[OPW-1:3];
        end else begin : g_nohi
            assign hi_bad = 1'b0;
        end
    endgenerate

    // Map the opcode to its control bundle; illegal opcodes decode to a NOP
    always_comb begin
        op1       = 1'b0;
        op2       = 1'b0;
        x8_sel    = '0;
        is_mem    = 1'b0;
        is_st     = 1'b0;
        is_br     = 1'b0;
        is_jmp    = 1'b0;
        writes_x8 = 1'b0;
        is_halt   = 1'b0;
        illegal   = 1'b0;
        if (hi_bad) begin
            illegal = 1'b1;
        end else begin
            case (opcode[2:0])
                OP_LI: begin
                    x8_sel    = X8SEL_W'(X8_IMM);
                    writes_x8 = 1'b1;
                end
                OP_ADD: begin
                    op1       = 1'b1;
                    x8_sel    = X8SEL_W'(X8_ALU);
                    writes_x8 = 1'b1;
                end
                OP_BEZ: begin
                    op2   = 1'b1;
                    is_br = 1'b1;
                end
                OP_LR: begin
                    is_mem    = 1'b1;
                    x8_sel    = X8SEL_W'(X8_MEM);
                    writes_x8 = 1'b1;
                end
                OP_SR: begin
                    is_mem = 1'b1;
                    is_st  = 1'b1;
                end
                OP_JA: begin
                    op1    = 1'b1;
                    op2    = 1'b1;
                    is_jmp = 1'b1;
                end
                OP_NOT: begin
                    op1       = 1'b1;
                    x8_sel    = X8SEL_W'(X8_NOT);
                    writes_x8 = 1'b1;
                end
                default: begin
`ifdef CTRL_HALT_EN
                    is_halt = 1'b1;
`else
                    illegal = 1'b1;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the McCoy core: FETCH -> DECODE ->
// EXEC or MEM (-> HALT), with single-cycle commit strobes.
// Build option: CTRL_HALT_EN enables the HALT state and resume input.
module ctrl_sequencer
    import mccoy_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int X8SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [OPW-1:0]     opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               op1,
    output logic               op2,
    output logic [X8SEL_W-1:0] x8_sel,
    output logic               writex8,
    output logic               write_reg,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               illegal,
    input  logic               resume,
    output logic               halted
);

    state_t state, state_nx;
    logic [OPW-1:0] ir;

    logic               dec_op1, dec_op2;
    logic [X8SEL_W-1:0] dec_x8_sel;
    logic               dec_is_mem, dec_is_st, dec_is_br, dec_is_jmp;
    logic               dec_writes_x8, dec_is_halt, dec_illegal;

    logic               ctl_op1, ctl_op2;
    logic [X8SEL_W-1:0] ctl_x8_sel;
    logic               ctl_is_st, ctl_is_br, ctl_is_jmp;
    logic               ctl_writes_x8, ctl_illegal;

    ctrl_decode #(
        .OPW     (OPW),
        .X8SEL_W (X8SEL_W)
    ) u_decode (
        .opcode    (ir),
        .op1       (dec_op1),
        .op2       (dec_op2),
        .x8_sel    (dec_x8_sel),
        .is_mem    (dec_is_mem),
        .is_st     (dec_is_st),
        .is_br     (dec_is_br),
        .is_jmp    (dec_is_jmp),
        .writes_x8 (dec_writes_x8),
        .is_halt   (dec_is_halt),
        .illegal   (dec_illegal)
    );

    // State register and instruction register (IR loads on accept)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_FETCH && instr_valid)
                ir <= opcode;
        end
    end

    // Control bundle captured at the end of DECODE and held until commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_op1       <= 1'b0;
            ctl_op2       <= 1'b0;
            ctl_x8_sel    <= '0;
            ctl_is_st     <= 1'b0;
            ctl_is_br     <= 1'b0;
            ctl_is_jmp    <= 1'b0;
            ctl_writes_x8 <= 1'b0;
            ctl_illegal   <= 1'b0;
        end else if (state == ST_DECODE) begin
            ctl_op1       <= dec_op1;
            ctl_op2       <= dec_op2;
            ctl_x8_sel    <= dec_x8_sel;
            ctl_is_st     <= dec_is_st;
            ctl_is_br     <= dec_is_br;
            ctl_is_jmp    <= dec_is_jmp;
            ctl_writes_x8 <= dec_writes_x8;
            ctl_illegal   <= dec_illegal;
        end
    end

    // Next-state and output decode; outputs depend on state, never on instr_valid
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        op1         = 1'b0;
        op2         = 1'b0;
        x8_sel      = '0;
        writex8     = 1'b0;
        write_reg   = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                // IR was loaded on accept, so the live decode is already valid here
                op1    = dec_op1;
                op2    = dec_op2;
                x8_sel = dec_x8_sel;
                if (dec_is_mem)
                    state_nx = ST_MEM;
                else if (dec_is_halt)
                    state_nx = ST_HALT;
                else
                    state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                op1     = ctl_op1;
                op2     = ctl_op2;
                x8_sel  = ctl_x8_sel;
                writex8 = ctl_writes_x8;
                illegal = ctl_illegal;
                if (ctl_is_jmp || (ctl_is_br && zero))
                    pc_load = 1'b1;
                else
                    pc_inc = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_MEM: begin
                op1     = ctl_op1;
                op2     = ctl_op2;
                x8_sel  = ctl_x8_sel;
                mem_req = 1'b1;
                if (mem_ready) begin
                    writex8   = ctl_writes_x8;
                    write_reg = ctl_is_st;
                    pc_inc    = 1'b1;
                    state_nx  = ST_FETCH;
                end
            end
            ST_HALT: begin
`ifdef CTRL_HALT_EN
                halted = 1'b1;
`endif
                if (resume) begin
                    pc_inc   = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            default: state_nx = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer (OPW=4 instance).
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] opcode = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req;
    logic       op1, op2;
    logic [1:0] x8_sel;
    logic       writex8, write_reg, pc_inc, pc_load, illegal;
    logic       resume = 1'b0;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Packed view: ready,mem_req,op1,op2,x8_sel[1:0],writex8,write_reg,pc_inc,pc_load,illegal,halted
    logic [11:0] outs;
    assign outs = {instr_ready, mem_req, op1, op2, x8_sel, writex8, write_reg,
                   pc_inc, pc_load, illegal, halted};

    ctrl_sequencer #(.OPW(4), .X8SEL_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .op1         (op1),
        .op2         (op2),
        .x8_sel      (x8_sel),
        .writex8     (writex8),
        .write_reg   (write_reg),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .illegal     (illegal),
        .resume      (resume),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ev(input logic rdy, input logic mem, input logic o1,
                                       input logic o2, input logic [1:0] sel, input logic wx,
                                       input logic wr, input logic pi, input logic pl,
                                       input logic il, input logic h);
        return {rdy, mem, o1, o2, sel, wx, wr, pi, pl, il, h};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [11:0] e;
        rst = 1'b1; instr_valid = 1'b1; opcode = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL reset_hold outs=%b expected=%b", outs, e); end
        instr_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        step();
        checks++; if (outs !== e) begin errors++; $display("FAIL reset_idle outs=%b expected=%b", outs, e); end
    endtask

    task automatic test_alu;
        logic [11:0] e;
        logic [3:0]  op;
        logic [1:0]  sel;
        logic        o1;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin op = 4'b0000; sel = 2'd1; o1 = 1'b0; end
                1:       begin op = 4'b0001; sel = 2'd2; o1 = 1'b1; end
                default: begin op = 4'b0111; sel = 2'd3; o1 = 1'b1; end
            endcase
            opcode = op; #1;
            e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL alu_fetch op=%b outs=%b expected=%b", op, outs, e); end
            step();
            e = ev(0,0,o1,0,sel,0,0,0,0,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL alu_decode op=%b outs=%b expected=%b", op, outs, e); end
            step();
            e = ev(0,0,o1,0,sel,1,0,1,0,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL alu_exec op=%b outs=%b expected=%b", op, outs, e); end
            step();
        end
        instr_valid = 1'b0; #1;
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL alu_back_fetch outs=%b expected=%b", outs, e); end
        step();
        checks++; if (outs !== e) begin errors++; $display("FAIL alu_idle outs=%b expected=%b", outs, e); end
    endtask

    task automatic test_branch;
        logic [11:0] e;
        logic [3:0]  op;
        logic        z, ld, o1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin op = 4'b0010; z = 1'b1; ld = 1'b1; o1 = 1'b0; end
                1:       begin op = 4'b0010; z = 1'b0; ld = 1'b0; o1 = 1'b0; end
                default: begin op = 4'b0110; z = 1'b0; ld = 1'b1; o1 = 1'b1; end
            endcase
            opcode = op; zero = z; instr_valid = 1'b1;
            step();
            instr_valid = 1'b0; #1;
            e = ev(0,0,o1,1,2'd0,0,0,0,0,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL br_decode op=%b outs=%b expected=%b", op, outs, e); end
            step();
            e = ev(0,0,o1,1,2'd0,0,0,!ld,ld,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL br_exec op=%b zero=%b outs=%b expected=%b", op, z, outs, e); end
            step();
            e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL br_fetch op=%b outs=%b expected=%b", op, outs, e); end
        end
        zero = 1'b0;
    endtask

    task automatic test_mem;
        logic [11:0] e;
        int cyc;
        // lr with mem_ready in the 4th MEM cycle
        opcode = 4'b0011; instr_valid = 1'b1; cyc = 0;
        step(); cyc++;
        instr_valid = 1'b0; mem_ready = 1'b1; #1;
        e = ev(0,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL lr_decode outs=%b expected=%b", outs, e); end
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); cyc++;
            e = ev(0,1,0,0,2'd0,0,0,0,0,0,0);
            checks++; if (outs !== e) begin errors++; $display("FAIL lr_wait%0d outs=%b expected=%b", k, outs, e); end
        end
        step(); cyc++;
        mem_ready = 1'b1; #1;
        e = ev(0,1,0,0,2'd0,1,0,1,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL lr_commit outs=%b expected=%b", outs, e); end
        step(); cyc++;
        mem_ready = 1'b0; #1;
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e || cyc != 6) begin errors++; $display("FAIL lr_reaccept outs=%b expected=%b cycles=%0d expected=6", outs, e, cyc); end
        // sr with mem_ready in the first MEM cycle
        opcode = 4'b0101; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        mem_ready = 1'b1; #1;
        e = ev(0,1,0,0,2'd0,0,1,1,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL sr_commit outs=%b expected=%b", outs, e); end
        step();
        mem_ready = 1'b0; #1;
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL sr_fetch outs=%b expected=%b", outs, e); end
    endtask

    task automatic test_mem_reset;
        logic [11:0] e;
        opcode = 4'b0101; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step(); step();
        e = ev(0,1,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL srrst_mem2 outs=%b expected=%b", outs, e); end
        rst = 1'b1; mem_ready = 1'b1; #1;
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL srrst_abort outs=%b expected=%b", outs, e); end
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
        step();
        checks++; if (outs !== e) begin errors++; $display("FAIL srrst_after outs=%b expected=%b", outs, e); end
    endtask

    task automatic test_illegal;
        logic [11:0] e;
        opcode = 4'b1001; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; #1;
        e = ev(0,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL ill_decode outs=%b expected=%b", outs, e); end
        step();
        e = ev(0,0,0,0,2'd0,0,0,1,0,1,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL ill_exec outs=%b expected=%b", outs, e); end
        step();
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL ill_fetch outs=%b expected=%b", outs, e); end
    endtask

    task automatic test_halt;
        logic [11:0] e;
        // resume outside HALT has no effect
        resume = 1'b1; #1;
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL resume_idle outs=%b expected=%b", outs, e); end
        step();
        checks++; if (outs !== e) begin errors++; $display("FAIL resume_idle2 outs=%b expected=%b", outs, e); end
        resume = 1'b0;
        opcode = 4'b0100; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; #1;
        e = ev(0,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL halt_decode outs=%b expected=%b", outs, e); end
        step();
`ifdef CTRL_HALT_EN
        e = ev(0,0,0,0,2'd0,0,0,0,0,0,1);
        for (int k = 0; k < 3; k++) begin
            checks++; if (outs !== e) begin errors++; $display("FAIL halt_hold%0d outs=%b expected=%b", k, outs, e); end
            step();
        end
        resume = 1'b1; #1;
        e = ev(0,0,0,0,2'd0,0,0,1,0,0,1);
        checks++; if (outs !== e) begin errors++; $display("FAIL halt_resume outs=%b expected=%b", outs, e); end
        step();
        resume = 1'b0; #1;
`else
        e = ev(0,0,0,0,2'd0,0,0,1,0,1,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL halt_illegal outs=%b expected=%b", outs, e); end
        step();
`endif
        e = ev(1,0,0,0,2'd0,0,0,0,0,0,0);
        checks++; if (outs !== e) begin errors++; $display("FAIL halt_fetch outs=%b expected=%b", outs, e); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_mem_reset();
        test_illegal();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer for the McCoy core, replacing the single-cycle combinational opcode decode. It accepts opcodes from fetch over a valid/ready handshake and latches the decoded controls. It sequences each instruction through DECODE, then EXEC or MEM, and commits register, x8 and PC updates as single-cycle strobes. Load and store instructions stall on a memory ready handshake, so the core can sit behind slow external memory.

## Interface
- OPW, 3: opcode width, ≥3; bits above [2:0] must be zero for a legal opcode
- X8SEL_W, 2: width of x8_sel
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  opcode valid from fetch
- instr_ready  out  1  sequencer can accept an opcode
- opcode  in  OPW  instruction opcode
- zero  in  1  x8 == 0, sampled in EXEC
- mem_ready  in  1  memory completes the current lr/sr
- mem_req  out  1  memory access pending
- op1, op2  out  1  operand selects, held DECODE→commit
- x8_sel  out  X8SEL_W  x8 write source (0 mem, 1 imm, 2 alu, 3 not)
- writex8, write_reg  out  1  commit strobes
- pc_inc, pc_load  out  1  PC update strobes, mutually exclusive
- illegal  out  1  illegal-opcode strobe
- resume  in  1  leave HALT (CTRL_HALT_EN only)
- halted  out  1  in HALT

## Operation
- Decode (opcode[2:0]): 000 li (x8_sel=1, writex8); 001 add (op1, x8_sel=2, writex8); 010 bez (op2, branch); 011 lr (mem, x8_sel=0, writex8); 101 sr (mem, write_reg); 110 ja (op1, op2, jump); 111 not (op1, x8_sel=3, writex8); 100 halt/illegal. Nonzero opcode[OPW-1:3] is illegal.
- States: FETCH, DECODE, EXEC, MEM, HALT. Reset enters FETCH.
- FETCH: instr_ready=1. On instr_valid, latch opcode into IR and go to DECODE.
- DECODE: register the control bundle. Go to MEM for lr/sr, HALT for 100 (macro on), else EXEC.
- EXEC, one cycle, then FETCH:
  - li/add/not: writex8=1, pc_inc=1.
  - bez: pc_load=1 if zero, else pc_inc=1.
  - ja: pc_load=1.
  - illegal: illegal=1, pc_inc=1, no write (NOP).
- MEM: mem_req=1 until mem_ready. On the mem_ready cycle, commit writex8 (lr) or write_reg (sr) plus pc_inc, then go to FETCH. mem_ready outside MEM is ignored.
- op1, op2 and x8_sel are 0 in FETCH and stable from DECODE until the commit cycle.

## Timing
- Reset (async): state FETCH, IR=0. All outputs 0 except instr_ready=1.
- Non-memory instruction: accept cycle + DECODE + EXEC = 3 cycles accept-to-accept.
- lr/sr: 2 + N cycles, N ≥ 1 = MEM cycles including the mem_ready cycle.
- instr_ready is purely state-decoded, with no combinational path from instr_valid.
- Commit strobes are exactly one cycle wide. writex8 and write_reg are never both high.
- Reset during MEM: mem_req drops immediately, no commit strobe, no PC update.

## Configuration
- CTRL_HALT_EN defined:
  - Opcode 100 → HALT: halted=1, instr_ready=0.
  - resume=1 in HALT → one-cycle pc_inc and return to FETCH.
  - resume outside HALT is ignored.
- CTRL_HALT_EN undefined:
  - 100 is illegal (NOP with illegal strobe).
  - halted tied 0, resume unused.

## Structure
- Package mccoy_pkg holds:
  - opcode localparams (OP_LI … OP_NOT, OP_HALT)
  - state encodings
  - x8_sel encodings X8_MEM/X8_IMM/X8_ALU/X8_NOT
- Sub-module ctrl_decode: combinational opcode → control bundle (op1, op2, x8_sel, is_mem, is_st, is_br, is_jmp, writes_x8, illegal).
- ctrl_sequencer contains the FSM, IR and control registers only.

## Test plan
- li then add then not, instr_valid held high → accepts every 3 cycles; writex8 pulses with x8_sel 1, 2, 3; pc_inc pulses 3 times; op1=1 only for add/not.
- bez with zero=1, then bez with zero=0 → first gives pc_load=1, second gives pc_inc=1; op2=1 in both; no writex8.
- lr with mem_ready after 4 MEM cycles → mem_req high 4 cycles, then writex8=1, x8_sel=0, pc_inc=1 in the mem_ready cycle; next accept 6 cycles after the first.
- sr, rst asserted on MEM cycle 2 → mem_req, write_reg and pc_inc all 0 immediately; instr_ready=1 after reset.
- OPW=4, opcode 4'b1001 → illegal=1 and pc_inc=1 in EXEC, no writex8.
- Opcode 100, macro on → halted=1 and instr_ready=0 until resume; resume gives one pc_inc, then FETCH. Macro off → illegal=1, halted stays 0.
